mem_cycle_sequencer: RTL
========================

Name: mem_cycle_sequencer

Overview:
- Sequences the CPU's memory-side datapath through FETCH, EXEC1 and EXEC2, and runs the Avalon-MM master handshake for both accesses.
- The instruction fetch and the single data access per instruction share one Avalon port, and this block arbitrates between them in time.
- It holds strobes across waitrequest, latches the fetched instruction and the load data, pulses a commit strobe, and halts the core when PC reaches zero.
- It drives the 2-bit state bus consumed by the load/store and register-file logic.

Parameters:
- RESET_VECTOR, 32'hBFC00000: PC value reported via pc_reset_val; informational only, the PC is owned by the PC block.
- HALT_ADDR, 32'h00000000: a fetch address equal to this value halts the core instead of issuing a read.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  32  current PC from the PC block
- is_load  in  1  decoded instruction needs a memory read (lb/lbu/lh/lhu/lw/lwl/lwr); sampled in EXEC1
- is_store  in  1  decoded instruction needs a memory write (sb/sh/sw); sampled in EXEC1
- data_address  in  32  effective address (rs + sign-extended offset)
- data_byteenable  in  4  byte lanes for the data access
- data_writedata  in  32  lane-aligned store data
- mem_address  out  32  Avalon address, always word-aligned
- mem_read  out  1  Avalon read strobe
- mem_write  out  1  Avalon write strobe
- mem_byteenable  out  4  Avalon byteenable
- mem_writedata  out  32  Avalon write data
- mem_waitrequest  in  1  Avalon waitrequest
- mem_readdata  in  32  Avalon read data
- state  out  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALTED
- instr_out  out  32  latched instruction word
- load_data  out  32  latched raw read word for load extraction
- commit  out  1  one-cycle pulse in EXEC2: register write and PC update allowed
- active  out  1  high until halted
- pc_reset_val  out  32  constant RESET_VECTOR

Behaviour:
- Reset (asynchronous, immediate):
  - state=FETCH, mem_read=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0.
  - instr_out=0, load_data=0, commit=0, active=1, internal issued flag=0.
- All outputs except pc_reset_val are registered.
- Transaction rule:
  - A strobe asserts on the clock edge after entry to the issuing state; address, byteenable and writedata are registered on the same edge.
  - The strobe and those values are held constant while mem_waitrequest=1.
  - The transfer completes on the first rising edge with strobe=1 and mem_waitrequest=0. On that edge the strobe drops and readdata is captured.
  - mem_read and mem_write are never high together.
- FETCH, when not issued:
  - If pc_in==HALT_ADDR: go to HALTED; active=0 on the same edge; no read issued.
  - Otherwise: mem_read=1, mem_address={pc_in[31:2],2'b00}, mem_byteenable=4'b1111.
- FETCH completion: instr_out<=mem_readdata, go to EXEC1. Minimum FETCH duration is 2 cycles.
- EXEC1, first cycle:
  - is_load: issue a read to {data_address[31:2],2'b00} with data_byteenable.
  - is_store: issue a write with data_byteenable and data_writedata.
  - Both asserted: treat as load; no write issued.
  - Neither asserted: go to EXEC2 on the next edge with no bus access.
- EXEC1 completion:
  - Load: load_data<=mem_readdata.
  - Then go to EXEC2.
- EXEC2:
  - commit=1 for exactly one cycle, then FETCH.
  - instr_out and load_data hold their values through EXEC2.
- HALTED:
  - Absorbing state; all strobes 0, active=0.
  - Exited only by reset.
- Timing with zero wait states:
  - Non-memory instruction: 4 cycles.
  - Load or store: 5 cycles.
  - Each waitrequest cycle adds 1 cycle.
- Data inputs (pc_in, data_address, data_byteenable, data_writedata) are sampled only on the issue edge; changes during a stall are ignored.
- Reset mid-transfer:
  - Strobes drop asynchronously and the transfer is abandoned.
  - No commit occurs and captured registers clear.
- Inputs must be known (not X) only on the edges where they are sampled.

Test Plan:
- Fetch, no stall: pc_in=32'hBFC00000, waitrequest=0, readdata=32'h24020005, is_load=is_store=0. Required:
  - mem_read high for 1 cycle with mem_address=32'hBFC00000 and be=1111.
  - instr_out=32'h24020005.
  - State sequence 00,01,10,00, with commit high in 10.
- Stalled load: data_address=32'h00001006, data_byteenable=4'b0100, is_load=1, waitrequest=1 for 3 cycles, readdata=32'h00AB0000. Required:
  - mem_read held 4 cycles at mem_address=32'h00001004.
  - load_data=32'h00AB0000.
  - One commit pulse.
- Store: is_store=1, data_writedata=32'h0000BEEF, be=4'b0011. Required:
  - mem_write high exactly 1 cycle.
  - mem_read=0 throughout EXEC1.
  - load_data unchanged.
- Halt: pc_in=0 on FETCH entry. Required:
  - state=11, active=0 next edge, and no mem_read ever asserted.
  - After 10 cycles still halted.
  - Asserting reset gives state=00 and active=1.
- Reset mid-stall: assert reset during an EXEC1 read with waitrequest=1. Required:
  - mem_read=0 and state=00 immediately without a clock edge.
  - commit is never pulsed.
- Simultaneous load and store: is_load=is_store=1. Required:
  - Only mem_read asserts; mem_write stays 0.

Source files
------------

// File: rtl/mem_cycle_sequencer.sv
// rtl/mem_cycle_sequencer.sv - FETCH/EXEC1/EXEC2 sequencer and Avalon-MM master for fetch and data access
module mem_cycle_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [1:0]  state,
  output logic [31:0] instr_out,
  output logic [31:0] load_data,
  output logic        commit,
  output logic        active,
  output logic [31:0] pc_reset_val
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC1  = 2'b01,
    EXEC2  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t      cur, nxt;
  logic        issued, issued_nxt;
  logic        read_nxt, write_nxt, commit_nxt, active_nxt;
  logic [31:0] addr_nxt, wdata_nxt, instr_nxt, load_nxt;
  logic [3:0]  be_nxt;
  logic        xfer_done;
  logic        unused_addr_bits;

  assign state            = cur;
  assign pc_reset_val     = RESET_VECTOR;
  assign unused_addr_bits = ^data_address[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur            <= FETCH;
      issued         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'h0;
      mem_byteenable <= 4'h0;
      mem_writedata  <= 32'h0;
      instr_out      <= 32'h0;
      load_data      <= 32'h0;
      commit         <= 1'b0;
      active         <= 1'b1;
    end else begin
      cur            <= nxt;
      issued         <= issued_nxt;
      mem_read       <= read_nxt;
      mem_write      <= write_nxt;
      mem_address    <= addr_nxt;
      mem_byteenable <= be_nxt;
      mem_writedata  <= wdata_nxt;
      instr_out      <= instr_nxt;
      load_data      <= load_nxt;
      commit         <= commit_nxt;
      active         <= active_nxt;
    end
  end

  always_comb begin
    nxt        = cur;
    issued_nxt = issued;
    read_nxt   = mem_read;
    write_nxt  = mem_write;
    addr_nxt   = mem_address;
    be_nxt     = mem_byteenable;
    wdata_nxt  = mem_writedata;
    instr_nxt  = instr_out;
    load_nxt   = load_data;
    commit_nxt = 1'b0;
    active_nxt = active;
    xfer_done  = (mem_read | mem_write) & ~mem_waitrequest;

    case (cur)
      FETCH: begin
        if (!issued) begin
          if (pc_in == HALT_ADDR) begin
            nxt        = HALTED;
            active_nxt = 1'b0;
          end else begin
            read_nxt   = 1'b1;
            addr_nxt   = {pc_in[31:2], 2'b00};
            be_nxt     = 4'b1111;
            issued_nxt = 1'b1;
          end
        end else if (xfer_done) begin
          read_nxt   = 1'b0;
          issued_nxt = 1'b0;
          instr_nxt  = mem_readdata;
          nxt        = EXEC1;
        end
      end
      EXEC1: begin
        if (!issued) begin
          // Load wins when decode flags both; the bus never sees read and write together.
          if (is_load) begin
            read_nxt   = 1'b1;
            addr_nxt   = {data_address[31:2], 2'b00};
            be_nxt     = data_byteenable;
            issued_nxt = 1'b1;
          end else if (is_store) begin
            write_nxt  = 1'b1;
            addr_nxt   = {data_address[31:2], 2'b00};
            be_nxt     = data_byteenable;
            wdata_nxt  = data_writedata;
            issued_nxt = 1'b1;
          end else begin
            nxt        = EXEC2;
            commit_nxt = 1'b1;
          end
        end else if (xfer_done) begin
          if (mem_read) begin
            load_nxt = mem_readdata;
          end
          read_nxt   = 1'b0;
          write_nxt  = 1'b0;
          issued_nxt = 1'b0;
          nxt        = EXEC2;
          commit_nxt = 1'b1;
        end
      end
      EXEC2: begin
        nxt = FETCH;
      end
      HALTED: begin
        read_nxt   = 1'b0;
        write_nxt  = 1'b0;
        active_nxt = 1'b0;
      end
    endcase
  end

endmodule
